// File: rtl/ocm_noise_streamer.sv
// Read master for the dual-port noise OCM: sweeps a word region cyclically, unpacks each word
// into signed noise samples and streams them over valid/ready behind a small prefetch FIFO.
module ocm_noise_streamer #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 64,
   parameter int SAMPLE_W   = 16,
   parameter int MEM_WORDS  = 8960,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic [ADDR_W-1:0]          base_addr_i,
   input  logic [ADDR_W:0]            num_words_i,
   output logic [ADDR_W-1:0]          ocm_address_o,
   output logic                       ocm_chipselect_o,
   output logic                       ocm_write_o,
   output logic [DATA_W/8-1:0]        ocm_byteenable_o,
   input  logic [DATA_W-1:0]          ocm_readdata_i,
   output logic                       noise_valid_o,
   input  logic                       noise_ready_i,
   output logic signed [SAMPLE_W-1:0] noise_sample_o,
   output logic                       busy_o,
   output logic                       cfg_err_o,
   output logic [15:0]                wrap_count_o
);

   localparam int LANES  = DATA_W / SAMPLE_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SUM_W  = ADDR_W + 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [15:0]         wrap_q, wrap_d;
   logic                inflight_q, inflight_d;
   logic                cfg_err_q, cfg_err_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [PTR_W-1:0]    wr_idx_q, wr_idx_d;
   logic [PTR_W-1:0]    rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];

   logic [SUM_W-1:0]    cfg_sum_s;
   logic                cfg_ok_s;
   logic                run_s;
   logic                idle_start_s;
   logic [CNT_W:0]      occ_s;
   logic                issue_s;
   logic                valid_s;
   logic                fire_s;
   logic                last_lane_s;
   logic                pop_s;
   logic                push_s;
   logic [DATA_W-1:0]   head_s;
   logic [SAMPLE_W-1:0] sample_s;

   assign cfg_sum_s    = SUM_W'(base_addr_i) + SUM_W'(num_words_i);
   assign cfg_ok_s     = (num_words_i != '0) && (cfg_sum_s <= SUM_W'(MEM_WORDS));
   assign run_s        = (state_q == ST_RUN);
   // stop beats a coincident start, so a start with stop never even reports a config error
   assign idle_start_s = (state_q == ST_IDLE) && start_i && !stop_i;
   assign occ_s        = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
   assign issue_s      = run_s && !stop_i && (occ_s < (CNT_W+1)'(FIFO_DEPTH));
   assign valid_s      = run_s && (count_q != '0);
   assign fire_s       = valid_s && noise_ready_i;
   assign last_lane_s  = (lane_q == LANE_W'(LANES - 1));
   assign pop_s        = fire_s && last_lane_s;
   assign push_s       = run_s && !stop_i && inflight_q;
   assign head_s       = fifo_q[rd_idx_q];

   generate
      if (LANES == 1) begin : g_one_lane
         assign sample_s = head_s[SAMPLE_W-1:0];
      end else begin : g_lanes
         logic [SAMPLE_W-1:0] lanes_s [LANES];
         for (genvar g = 0; g < LANES; g++) begin : g_unpack
            assign lanes_s[g] = head_s[g*SAMPLE_W +: SAMPLE_W];
         end
         assign sample_s = lanes_s[lane_q];
      end
   endgenerate

   assign ocm_address_o    = rd_ptr_q;
   assign ocm_chipselect_o = issue_s;
   assign ocm_write_o      = 1'b0;
   assign ocm_byteenable_o = '1;
   assign noise_valid_o    = valid_s;
   assign noise_sample_o   = valid_s ? sample_s : '0;
   assign busy_o           = run_s;
   assign cfg_err_o        = cfg_err_q;
   assign wrap_count_o     = wrap_q;

   // Next-state logic for the IDLE/RUN controller
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (idle_start_s && cfg_ok_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next-state logic for read pointer, wrap counter, FIFO pointers and lane selector
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      base_d     = base_q;
      last_d     = last_q;
      wrap_d     = wrap_q;
      inflight_d = inflight_q;
      lane_d     = lane_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      count_d    = count_q;
      cfg_err_d  = idle_start_s && !cfg_ok_s;
      if (idle_start_s && cfg_ok_s) begin
         rd_ptr_d   = base_addr_i;
         base_d     = base_addr_i;
         last_d     = ADDR_W'(cfg_sum_s - SUM_W'(1));
         wrap_d     = 16'd0;
         inflight_d = 1'b0;
         lane_d     = '0;
         wr_idx_d   = '0;
         rd_idx_d   = '0;
         count_d    = '0;
      end else if (run_s && stop_i) begin
         // any word still in flight is dropped by clearing inflight
         inflight_d = 1'b0;
         lane_d     = '0;
         wr_idx_d   = '0;
         rd_idx_d   = '0;
         count_d    = '0;
      end else if (run_s) begin
         inflight_d = issue_s;
         if (issue_s) begin
            if (rd_ptr_q == last_q) begin
               rd_ptr_d = base_q;
               if (wrap_q != 16'hFFFF) begin
                  wrap_d = wrap_q + 16'd1;
               end else begin
                  wrap_d = wrap_q;
               end
            end else begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (push_s) begin
            wr_idx_d = wr_idx_q + PTR_W'(1);
         end else begin
            wr_idx_d = wr_idx_q;
         end
         if (pop_s) begin
            rd_idx_d = rd_idx_q + PTR_W'(1);
         end else begin
            rd_idx_d = rd_idx_q;
         end
         count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
         if (fire_s) begin
            lane_d = last_lane_s ? '0 : lane_q + LANE_W'(1);
         end else begin
            lane_d = lane_q;
         end
      end else begin
         inflight_d = 1'b0;
      end
   end

   // Control and pointer registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         rd_ptr_q   <= '0;
         base_q     <= '0;
         last_q     <= '0;
         wrap_q     <= 16'd0;
         inflight_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         lane_q     <= '0;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         base_q     <= base_d;
         last_q     <= last_d;
         wrap_q     <= wrap_d;
         inflight_q <= inflight_d;
         cfg_err_q  <= cfg_err_d;
         lane_q     <= lane_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         count_q    <= count_d;
      end
   end

   // Prefetch FIFO storage; contents only matter while count is non-zero
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         fifo_q[wr_idx_q] <= ocm_readdata_i;
      end
   end

endmodule

// File: tb/tb_ocm_noise_streamer.sv
// Bench for ocm_noise_streamer: random backpressure against a region/lane arithmetic model.
module tb_ocm_noise_streamer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [13:0] base_addr = 14'd0;
   logic [14:0] num_words = 15'd0;
   logic [13:0] ocm_addr;
   logic        ocm_cs;
   logic        ocm_write;
   logic [7:0]  ocm_be;
   logic [63:0] rdata = 64'd0;
   logic        nvalid;
   logic        noise_ready = 1'b1;
   logic [15:0] nsample;
   logic        busy;
   logic        cfg_err;
   logic [15:0] wrap;

   logic        sat_start = 1'b0;
   logic        sat_stop = 1'b0;
   logic [13:0] sat_base = 14'd100;
   logic [14:0] sat_num = 15'd1;
   logic [13:0] sat_addr;
   logic        sat_cs;
   logic        sat_write;
   logic [7:0]  sat_be;
   logic [63:0] sat_rdata = 64'h0123_4567_89AB_CDEF;
   logic        sat_valid;
   logic        sat_ready = 1'b1;
   logic [63:0] sat_sample;
   logic        sat_busy;
   logic        sat_cfg_err;
   logic [15:0] sat_wrap;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ocm_noise_streamer dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop),
      .base_addr_i(base_addr), .num_words_i(num_words),
      .ocm_address_o(ocm_addr), .ocm_chipselect_o(ocm_cs), .ocm_write_o(ocm_write),
      .ocm_byteenable_o(ocm_be), .ocm_readdata_i(rdata),
      .noise_valid_o(nvalid), .noise_ready_i(noise_ready), .noise_sample_o(nsample),
      .busy_o(busy), .cfg_err_o(cfg_err), .wrap_count_o(wrap)
   );

   ocm_noise_streamer #(.SAMPLE_W(64)) u_sat (
      .clk_i(clk), .reset_i(reset), .start_i(sat_start), .stop_i(sat_stop),
      .base_addr_i(sat_base), .num_words_i(sat_num),
      .ocm_address_o(sat_addr), .ocm_chipselect_o(sat_cs), .ocm_write_o(sat_write),
      .ocm_byteenable_o(sat_be), .ocm_readdata_i(sat_rdata),
      .noise_valid_o(sat_valid), .noise_ready_i(sat_ready), .noise_sample_o(sat_sample),
      .busy_o(sat_busy), .cfg_err_o(sat_cfg_err), .wrap_count_o(sat_wrap)
   );

   // OCM word k holds samples k, k+1, k+2, k+3 (lane 0 in the low bits)
   function automatic logic [63:0] word_of(input logic [13:0] k);
      logic [15:0] k16;
      k16 = 16'(k);
      return {4{k16}} + 64'h0003_0002_0001_0000;
   endfunction

   // OCM port model with one clock of read latency
   always @(posedge clk) begin
      if (ocm_cs) rdata <= word_of(ocm_addr);
   end

   task automatic start_cfg(input int b, input int n);
      @(negedge clk);
      base_addr = 14'(b);
      num_words = 15'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic stream(input int b, input int n, input int ncyc, input bit rnd);
      int          words = 0;
      int          n_iss = 0;
      int          n_smp = 0;
      int          exp_s;
      bit          infl = 1'b0;
      bit          stalled = 1'b0;
      bit          exp_cs;
      bit          pop;
      logic [15:0] held = 16'd0;
      start_cfg(b, n);
      for (int i = 0; i < ncyc; i++) begin
         if (i > 0) @(negedge clk);
         noise_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
         #1;
         exp_cs = (words + int'(infl)) < 4;
         checks++;
         if (ocm_cs !== exp_cs || ocm_write !== 1'b0) begin
            errors++;
            $display("FAIL stream_cs b=%0d cyc=%0d cs=%b write=%b expected cs=%b write=0", b, i, ocm_cs, ocm_write, exp_cs);
         end
         checks++;
         if (wrap !== 16'(n_iss / n)) begin
            errors++;
            $display("FAIL stream_wrap b=%0d cyc=%0d got %0d expected %0d", b, i, wrap, n_iss / n);
         end
         if (exp_cs) begin
            checks++;
            if (ocm_addr !== 14'(b + n_iss % n)) begin
               errors++;
               $display("FAIL stream_addr issue=%0d got %0d expected %0d", n_iss, ocm_addr, b + n_iss % n);
            end
            n_iss++;
         end
         checks++;
         if (nvalid !== (words > 0)) begin
            errors++;
            $display("FAIL stream_valid b=%0d cyc=%0d got %b expected %b", b, i, nvalid, words > 0);
         end
         pop = 1'b0;
         if (words > 0) begin
            exp_s = b + (n_smp / 4) % n + n_smp % 4;
            checks++;
            if (nsample !== 16'(exp_s)) begin
               errors++;
               $display("FAIL stream_sample idx=%0d got %0d expected %0d", n_smp, nsample, exp_s);
            end
            if (stalled) begin
               checks++;
               if (nsample !== held) begin
                  errors++;
                  $display("FAIL stream_hold cyc=%0d got %0d expected %0d", i, nsample, held);
               end
            end
            if (noise_ready) begin
               n_smp++;
               stalled = 1'b0;
               pop = (n_smp % 4 == 0);
            end else begin
               stalled = 1'b1;
               held = 16'(exp_s);
            end
         end
         words = words + int'(infl) - int'(pop);
         infl = exp_cs;
      end
      @(negedge clk);
      stop = 1'b1;
      #1;
      checks++;
      if (ocm_cs !== 1'b0) begin
         errors++;
         $display("FAIL stream_stop_cs got %b expected 0", ocm_cs);
      end
      @(negedge clk);
      stop = 1'b0;
      #1;
      checks++;
      if ({busy, nvalid, ocm_cs} !== 3'b000) begin
         errors++;
         $display("FAIL stream_stopped busy/valid/cs got %b expected 000", {busy, nvalid, ocm_cs});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({ocm_addr, ocm_cs, ocm_write, ocm_be, nvalid, nsample, busy, cfg_err, wrap} !==
          {14'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL reset_outputs addr=%0d cs=%b wr=%b be=%h v=%b s=%h busy=%b err=%b wrap=%0d expected 0 except be=ff",
                  ocm_addr, ocm_cs, ocm_write, ocm_be, nvalid, nsample, busy, cfg_err, wrap);
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({busy, ocm_cs, nvalid, cfg_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle busy/cs/valid/err got %b expected 0000", {busy, ocm_cs, nvalid, cfg_err});
      end
   endtask

   task automatic test_cfg_err();
      start_cfg(0, 0);
      #1;
      checks++;
      if ({cfg_err, busy} !== 2'b10) begin
         errors++;
         $display("FAIL cfg_num0 err/busy got %b expected 10", {cfg_err, busy});
      end
      @(negedge clk);
      #1;
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL cfg_pulse got %b expected 0", cfg_err);
      end
      start_cfg(8950, 11);
      #1;
      checks++;
      if ({cfg_err, busy} !== 2'b10) begin
         errors++;
         $display("FAIL cfg_overrun err/busy got %b expected 10", {cfg_err, busy});
      end
      start_cfg(8950, 10);
      #1;
      checks++;
      if ({cfg_err, busy} !== 2'b01) begin
         errors++;
         $display("FAIL cfg_edge_ok err/busy got %b expected 01", {cfg_err, busy});
      end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      stream(8950, 10, 70, 1'b0);
   endtask

   task automatic test_stop_restart();
      start_cfg(0, 3);
      noise_ready = 1'b1;
      start = 1'b1;
      num_words = 15'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if ({cfg_err, busy, ocm_cs} !== 3'b011) begin
         errors++;
         $display("FAIL start_in_run err/busy/cs got %b expected 011", {cfg_err, busy, ocm_cs});
      end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      #1;
      checks++;
      if ({nvalid, busy, ocm_cs} !== 3'b000) begin
         errors++;
         $display("FAIL stop_after_issue valid/busy/cs got %b expected 000", {nvalid, busy, ocm_cs});
      end
      stream(5, 4, 40, 1'b0);
   endtask

   task automatic test_reset_midrun();
      start_cfg(0, 3);
      noise_ready = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if ({nvalid, nsample, ocm_cs} !== {1'b1, 16'd0, 1'b0}) begin
         errors++;
         $display("FAIL full_fifo valid/sample/cs got %b/%0d/%b expected 1/0/0", nvalid, nsample, ocm_cs);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({ocm_addr, ocm_cs, ocm_write, ocm_be, nvalid, nsample, busy, cfg_err, wrap} !==
          {14'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL midrun_reset addr=%0d cs=%b v=%b s=%h busy=%b wrap=%0d expected all 0",
                  ocm_addr, ocm_cs, nvalid, nsample, busy, wrap);
      end
      reset = 1'b0;
      noise_ready = 1'b1;
      @(negedge clk);
      base_addr = 14'd0;
      num_words = 15'd3;
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      base_addr = 14'd0;
      num_words = 15'd0;
      #1;
      checks++;
      if ({busy, cfg_err} !== 2'b00) begin
         errors++;
         $display("FAIL start_stop_good busy/err got %b expected 00", {busy, cfg_err});
      end
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      #1;
      checks++;
      if ({busy, cfg_err} !== 2'b00) begin
         errors++;
         $display("FAIL start_stop_bad busy/err got %b expected 00", {busy, cfg_err});
      end
   endtask

   task automatic test_saturate();
      int n_iss = 0;
      int exp_w;
      @(negedge clk);
      sat_start = 1'b1;
      @(negedge clk);
      sat_start = 1'b0;
      for (int i = 0; i < 65600; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         exp_w = (n_iss > 65535) ? 65535 : n_iss;
         checks++;
         if (sat_wrap !== 16'(exp_w)) begin
            errors++;
            $display("FAIL sat_wrap cyc=%0d got %0d expected %0d", i, sat_wrap, exp_w);
         end
         if (sat_cs) begin
            checks++;
            if (sat_addr !== 14'd100) begin
               errors++;
               $display("FAIL sat_addr cyc=%0d got %0d expected 100", i, sat_addr);
            end
            n_iss++;
         end
      end
      checks++;
      if (sat_wrap !== 16'hFFFF || n_iss < 65536) begin
         errors++;
         $display("FAIL sat_final wrap=%h issues=%0d expected wrap=ffff with >65535 issues", sat_wrap, n_iss);
      end
   endtask

   initial begin
      test_reset();
      stream(0, 3, 60, 1'b0);
      stream(0, 3, 200, 1'b1);
      test_cfg_err();
      stream(100, 1, 40, 1'b0);
      stream(37, 7, 150, 1'b1);
      test_stop_restart();
      test_reset_midrun();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
